// File: rtl/mgu_pkg.sv
// mgu_pkg: shared truth-table types, preset tables and config FSM states
package mgu_pkg;
    typedef logic [3:0] tt_t;
    localparam tt_t TT_AND  = 4'h8;
    localparam tt_t TT_OR   = 4'hE;
    localparam tt_t TT_XOR  = 4'h6;
    localparam tt_t TT_NAND = 4'h7;
    typedef enum logic {FILL, COMMIT} cfg_state_e;
    // Table bit {a,b} is the output for that operand pair (bit0 = a0b0, bit3 = a1b1)
    function automatic logic tt_eval(tt_t tt, logic a, logic b);
        return tt[{a, b}];
    endfunction
endpackage

// File: rtl/mgu_sync.sv
// mgu_sync: enable-gated multi-stage synchroniser for asynchronous operand bits
module mgu_sync #(
    parameter int W      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] chain [STAGES];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else if (ena) begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/multi_gate_unit.sv
// multi_gate_unit: N-channel programmable 2-input logic with atomic table load and edge counter
module multi_gate_unit
    import mgu_pkg::*;
#(
    parameter int  N_CH        = 8,
    parameter int  SYNC_STAGES = 2,
    parameter int  CNT_W       = 8,
    parameter tt_t RESET_TT    = TT_OR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_CH-1:0]  a_in,
    input  logic [N_CH-1:0]  b_in,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_data,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic             cnt_clr,
    output logic [N_CH-1:0]  y_out,
    output logic [CNT_W-1:0] edge_cnt
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    logic [2*N_CH-1:0] ab_s;
    logic [N_CH-1:0]   a_s, b_s, y_nxt;
    tt_t               active [N_CH];
    tt_t               shadow [N_CH];
    cfg_state_e        state, state_nxt;
    logic [PW-1:0]     wr_ptr;
    logic              accept, last, y0_d;
    mgu_sync #(.W(2*N_CH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     ({a_in, b_in}),
        .q     (ab_s)
    );
    assign a_s = ab_s[2*N_CH-1:N_CH];
    assign b_s = ab_s[N_CH-1:0];
    always_comb begin
        cfg_ready = ena && (state == FILL);
        cfg_done  = ena && (state == COMMIT);
        accept    = cfg_valid && cfg_ready;
        last      = (wr_ptr == PW'(N_CH-1));
        state_nxt = (state == FILL && accept && last) ? COMMIT : FILL;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else if (ena) state <= state_nxt;
    end
    // Shadow fills word by word; active only changes in the single COMMIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= RESET_TT;
                active[i] <= RESET_TT;
            end
        end else if (ena) begin
            if (accept) begin
                shadow[wr_ptr] <= cfg_data;
                wr_ptr         <= last ? '0 : wr_ptr + 1'b1;
            end
            if (state == COMMIT) active <= shadow;
        end
    end
    always_comb begin
        y_nxt = '0;
        for (int i = 0; i < N_CH; i++) y_nxt[i] = tt_eval(active[i], a_s[i], b_s[i]);
    end
    // Edge detect on the registered output; clear has priority over a coincident edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out    <= '0;
            y0_d     <= 1'b0;
            edge_cnt <= '0;
        end else if (ena) begin
            y_out    <= y_nxt;
            y0_d     <= y_out[0];
            edge_cnt <= cnt_clr ? '0
                      : (y_out[0] && !y0_d && edge_cnt != '1) ? edge_cnt + 1'b1
                      : edge_cnt;
        end
    end
endmodule

// File: tb/tb_multi_gate_unit.sv
// tb_multi_gate_unit: directed + random checks of multi_gate_unit against a behavioural model
module tb_multi_gate_unit;
    import mgu_pkg::*;
    localparam int N = 8;
    localparam int SS = 2;
    localparam int CMAX = 15;
    logic clk = 0, rst_n = 1, ena = 1, cfg_valid = 0, cnt_clr = 0;
    logic [N-1:0] a_in = 0, b_in = 0;
    logic [3:0] cfg_data = 0;
    logic cfg_ready, cfg_done;
    logic [N-1:0] y_out;
    logic [3:0] edge_cnt;
    int n_pass = 0, n_total = 0, n_acc = 0;
    logic [3:0] m_act [N];
    logic [3:0] m_sh [N];
    int m_ptr, m_cnt;
    bit m_commit;
    logic [2*N-1:0] m_dl [$];
    logic [N-1:0] m_y, m_yp;

    multi_gate_unit #(.N_CH(N), .SYNC_STAGES(SS), .CNT_W(4), .RESET_TT(TT_OR)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .a_in(a_in), .b_in(b_in),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .cfg_done(cfg_done), .cnt_clr(cnt_clr), .y_out(y_out), .edge_cnt(edge_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    function automatic logic [N-1:0] lookup(input logic [2*N-1:0] ab);
        logic [N-1:0] r;
        logic [3:0] tt;
        r = '0;
        for (int i = 0; i < N; i++) begin
            tt = m_act[i];
            r[i] = tt[{ab[N+i], ab[i]}];
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin m_act[i] = TT_OR; m_sh[i] = TT_OR; end
        m_ptr = 0; m_commit = 0; m_cnt = 0; m_y = 0; m_yp = 0;
        m_dl.delete();
        repeat (SS) m_dl.push_back('0);
    endtask

    // One enabled clock edge: outputs reflect inputs seen SS edges earlier, tables swap after a full set
    task automatic m_edge();
        logic [N-1:0] yn;
        yn = lookup(m_dl.pop_front());
        m_dl.push_back({a_in, b_in});
        if (cnt_clr) m_cnt = 0;
        else if (m_y[0] && !m_yp[0] && m_cnt < CMAX) m_cnt++;
        m_yp = m_y;
        m_y = yn;
        if (m_commit) begin
            m_act = m_sh;
            m_commit = 0;
        end else if (cfg_valid) begin
            m_sh[m_ptr] = cfg_data;
            n_acc++;
            if (m_ptr == N-1) begin m_ptr = 0; m_commit = 1; end
            else m_ptr++;
        end
    endtask

    task automatic chk_all();
        chk("y_out", y_out, m_y);
        chk("edge_cnt", edge_cnt, m_cnt);
        chk("cfg_ready", cfg_ready, ena && !m_commit);
        chk("cfg_done", cfg_done, ena && m_commit);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && ena) m_edge();
        #1 chk_all();
    endtask

    task automatic load(input logic [3:0] d, input int cnt);
        int target, g;
        target = n_acc + cnt;
        g = 0;
        cfg_valid = 1;
        cfg_data = d;
        while (n_acc < target && g < 100) begin tick(); g++; end
        cfg_valid = 0;
        chk("load_words", n_acc, target);
    endtask

    initial begin
        int g;
        m_reset();
        #2 rst_n = 0;
        #1 chk_all();
        chk("rst_y", y_out, 0);
        chk("rst_ready", cfg_ready, 1);
        @(negedge clk) rst_n = 1;
        // Latency with default OR tables
        a_in = 8'h01;
        tick(); chk("lat1", y_out, 0);
        tick(); chk("lat2", y_out, 0);
        tick(); chk("lat3", y_out, 8'h01);
        // Full AND load
        a_in = 8'hFF; b_in = 8'hFF;
        load(TT_AND, 8);
        chk("commit_ready", cfg_ready, 0);
        chk("commit_done", cfg_done, 1);
        tick(); chk("done_pulse", cfg_done, 0);
        tick(); chk("and_ff", y_out, 8'hFF);
        b_in = 8'h0F;
        repeat (3) tick();
        chk("and_0f", y_out, 8'h0F);
        // Partial XOR load leaves AND active
        b_in = 8'hFF;
        load(TT_XOR, 5);
        repeat (6) tick();
        chk("partial_y", y_out, 8'hFF);
        chk("partial_done", cfg_done, 0);
        load(TT_XOR, 3);
        chk("xor_done", cfg_done, 1);
        tick(); tick();
        chk("xor_y", y_out, 8'h00);
        // Edge counter saturation and clear priority (ch0 XOR with b=0 follows a)
        a_in = 0; b_in = 0;
        cnt_clr = 1; tick(); cnt_clr = 0;
        repeat (3) tick();
        repeat (20) begin
            a_in[0] = 1; tick(); tick();
            a_in[0] = 0; tick(); tick();
        end
        repeat (4) tick();
        chk("cnt_sat", edge_cnt, 15);
        a_in[0] = 1;
        g = 0;
        while (!(m_y[0] && !m_yp[0]) && g < 10) begin tick(); g++; end
        chk("rise_found", g < 10, 1);
        cnt_clr = 1; tick(); cnt_clr = 0;
        chk("clr_wins", edge_cnt, 0);
        // ena gap mid-load
        load(TT_NAND, 2);
        ena = 0; cfg_valid = 1; cfg_data = TT_AND;
        repeat (10) begin
            a_in = N'($urandom); b_in = N'($urandom);
            tick();
            chk("gap_ready", cfg_ready, 0);
        end
        ena = 1;
        g = n_acc;
        tick();
        chk("resume_acc", n_acc, g + 1);
        load(TT_AND, 5);
        a_in = 8'hA5; b_in = 8'h3C;
        repeat (4) tick();
        // Reset in the middle of a load
        load(TT_XOR, 4);
        #2 rst_n = 0;
        #1 chk("arst_y", y_out, 0);
        chk("arst_cnt", edge_cnt, 0);
        chk("arst_ready", cfg_ready, 1);
        chk("arst_done", cfg_done, 0);
        m_reset();
        @(negedge clk) rst_n = 1;
        load(TT_XOR, 7);
        chk("post_rst_nodone", cfg_done, 0);
        load(TT_XOR, 1);
        chk("post_rst_done", cfg_done, 1);
        // Random traffic
        repeat (400) begin
            a_in = N'($urandom); b_in = N'($urandom);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data = 4'($urandom);
            cnt_clr = ($urandom_range(0, 15) == 0);
            ena = ($urandom_range(0, 7) != 0);
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
